ultrasonic_echo_responder: RTL and testbench
============================================

# ultrasonic_echo_responder

Synthesizable HC-SR04 sensor emulator: the responder end of the trig/echo ranging interface. It accepts a trigger pulse, waits the sensor's burst time, then drives an echo pulse whose width encodes a programmable distance. It sits in place of the physical sensor, for hardware-in-the-loop bring-up and for simulation of the ranging driver and interaction logic.

## Interface
- TRIG_MIN_CYC, 500, minimum valid trig high time (10 µs @ 50 MHz)
- BURST_CYC, 10000, trig-fall to echo-rise delay (200 µs)
- CYC_PER_CM, 2900, echo cycles per cm (58 µs)
- MAX_CM, 400, largest in-range distance
- TIMEOUT_CYC, 1900000, echo width for no object (38 ms)
- HOLDOFF_CYC, 50000, dead time after echo falls
- clk  in  1  system clock, 50 MHz
- rst_n  in  1  synchronous, active-low reset
- trig  in  1  trigger from ranging driver
- dist_cm  in  9  emulated distance in cm; sampled once per measurement
- echo  out  1  echo pulse, registered
- busy  out  1  high from accepted trig fall until HOLDOFF ends
- no_obj  out  1  latched: current/last measurement used TIMEOUT_CYC
- trig_short  out  1  one-cycle pulse: trig rejected as too short

## Operation
- trig_s: conditioned trig (see Configuration). rise/fall detected against its registered copy.
- States: IDLE, TRIG_HI, BURST, ECHO, HOLDOFF.
- IDLE: on trig_s rising edge -> TRIG_HI, hi_cnt=1. A trig_s already high on IDLE entry is not a rise; wait for low first.
- TRIG_HI: hi_cnt increments, saturates at TRIG_MIN_CYC. On trig_s low: if hi_cnt >= TRIG_MIN_CYC, latch dist_cm -> BURST, busy=1; else pulse trig_short -> IDLE.
- Latch: dist_cm==0 or > MAX_CM -> N = TIMEOUT_CYC, no_obj=1; else N = dist_cm × CYC_PER_CM, no_obj=0.
- N generated without a multiplier: nested down-counters cm_cnt (9 b) and sub_cnt (12 b); timeout path uses a 21-bit counter (max 1,900,000 < 2^21).
- BURST: echo=0 for BURST_CYC cycles -> ECHO.
- ECHO: echo=1 for exactly N cycles -> HOLDOFF.
- HOLDOFF: echo=0 for HOLDOFF_CYC cycles, then busy=0 -> IDLE.
- trig activity during BURST/ECHO/HOLDOFF is ignored; no trig_short generated.
- dist_cm changes after latch do not affect the current echo.

## Timing
- Reset (rst_n low at clk edge): state IDLE, all counters 0, echo=0, busy=0, no_obj=0, trig_short=0. Reset mid-measurement aborts; echo low the next cycle.
- Let k = edge where trig_s first sampled low in TRIG_HI. State BURST, busy=1 from k+1. echo rises at edge k+1+BURST_CYC, falls at k+1+BURST_CYC+N.
- busy falls at edge k+1+BURST_CYC+N+HOLDOFF_CYC.
- trig_short high for exactly the cycle after k.
- Minimum trig-fall to next accepted measurement: BURST_CYC+N+HOLDOFF_CYC+1 cycles.

## Configuration
- ECHO_TRIG_SYNC_EN defined: trig passes a 2-flop synchronizer; trig_s = trig delayed 2 clk; all edges above shift by 2 relative to trig pins. For trig driven from a pin or another clock domain.
- Undefined: trig_s = trig directly (same-clock loopback); no added latency.

## Structure
- Shared package: state encoding (5 states, 3 b), default timing constants, DIST_W=9, ECHO_CNT_W=21.
- One sub-module: echo_sync2 (2-flop synchronizer, rst_n-cleared), instantiated only under ECHO_TRIG_SYNC_EN.
- FSM, counters, latch in top.

## Test plan
Sim params: TRIG_MIN_CYC=5, BURST_CYC=20, CYC_PER_CM=10, MAX_CM=40, TIMEOUT_CYC=600, HOLDOFF_CYC=50, macro undefined.
- dist_cm=10, trig high 6 cycles -> echo rises 21 cycles after trig fall edge k, high exactly 100 cycles; busy low 50 cycles after echo falls; no_obj=0.
- trig high 4 cycles -> trig_short one cycle, echo stays 0, busy stays 0.
- dist_cm=0, then 41 -> echo high 600 cycles each, no_obj=1; dist_cm=40 -> 400 cycles, no_obj=0.
- Retrigger 6-cycle pulse during ECHO and HOLDOFF -> ignored; trig still high when HOLDOFF ends -> no new measurement until low->high.
- rst_n low mid-ECHO -> next cycle echo=0, busy=0; fresh trig then measures normally. Change dist_cm mid-BURST -> echo width uses latched value.
- Default params, driver stimulus trig 501 cycles: dist_cm=8 -> echo 23200 cycles (below 25000 interaction threshold); dist_cm=9 -> 26100 cycles (above). Repeat with ECHO_TRIG_SYNC_EN: all edges +2 cycles.

Source files
------------

// File: rtl/ultrasonic_echo_responder_pkg.sv
// Shared encodings and default timing for the HC-SR04 echo responder.
// Defaults assume a 50 MHz clock.
package ultrasonic_echo_responder_pkg;

    localparam int DIST_W     = 9;
    localparam int ECHO_CNT_W = 21;
    localparam int SUB_W      = 12;

    localparam int DEF_TRIG_MIN_CYC = 500;
    localparam int DEF_BURST_CYC    = 10000;
    localparam int DEF_CYC_PER_CM   = 2900;
    localparam int DEF_MAX_CM       = 400;
    localparam int DEF_TIMEOUT_CYC  = 1900000;
    localparam int DEF_HOLDOFF_CYC  = 50000;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_TRIG_HI = 3'd1;
    localparam logic [2:0] ST_BURST   = 3'd2;
    localparam logic [2:0] ST_ECHO    = 3'd3;
    localparam logic [2:0] ST_HOLDOFF = 3'd4;

    // Zero and anything beyond the sensor's range are reported as "no object".
    function automatic logic dist_valid(input logic [DIST_W-1:0] d, input int max_cm);
        return (d != '0) && (int'(d) <= max_cm);
    endfunction

endpackage

// File: rtl/echo_sync2.sv
// Two-flop synchronizer for the trig input, cleared by rst_n.
// Used only when ECHO_TRIG_SYNC_EN is defined.
module echo_sync2
    import ultrasonic_echo_responder_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/ultrasonic_echo_responder.sv
// HC-SR04 responder: validates trig, waits the burst time, emits an echo of programmed width.
// Define ECHO_TRIG_SYNC_EN to pass trig through a 2-flop synchronizer (adds 2 cycles).
module ultrasonic_echo_responder
    import ultrasonic_echo_responder_pkg::*;
#(
    parameter int TRIG_MIN_CYC = DEF_TRIG_MIN_CYC,
    parameter int BURST_CYC    = DEF_BURST_CYC,
    parameter int CYC_PER_CM   = DEF_CYC_PER_CM,
    parameter int MAX_CM       = DEF_MAX_CM,
    parameter int TIMEOUT_CYC  = DEF_TIMEOUT_CYC,
    parameter int HOLDOFF_CYC  = DEF_HOLDOFF_CYC
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              trig,
    input  logic [DIST_W-1:0] dist_cm,
    output logic              echo,
    output logic              busy,
    output logic              no_obj,
    output logic              trig_short
);

    localparam int HI_W = $clog2(TRIG_MIN_CYC + 1);
    localparam logic [HI_W-1:0]       HI_MIN     = HI_W'(TRIG_MIN_CYC);
    localparam logic [ECHO_CNT_W-1:0] BURST_LOAD = ECHO_CNT_W'(BURST_CYC - 1);
    localparam logic [ECHO_CNT_W-1:0] TMO_LOAD   = ECHO_CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [ECHO_CNT_W-1:0] HOLD_LOAD  = ECHO_CNT_W'(HOLDOFF_CYC - 1);
    localparam logic [SUB_W-1:0]      SUB_LOAD   = SUB_W'(CYC_PER_CM - 1);

    logic trig_s;

`ifdef ECHO_TRIG_SYNC_EN
    echo_sync2 u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (trig),
        .q     (trig_s)
    );
`else
    assign trig_s = trig;
`endif

    logic                  trig_q;
    logic                  trig_rise;
    logic [2:0]            state;
    logic [HI_W-1:0]       hi_cnt;
    logic [ECHO_CNT_W-1:0] cnt;
    logic [DIST_W-1:0]     cm_cnt;
    logic [SUB_W-1:0]      sub_cnt;

    // trig_q tracks trig_s in every state, so a trig still high on return to IDLE is not a rise.
    assign trig_rise = trig_s & ~trig_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            trig_q     <= 1'b0;
            hi_cnt     <= '0;
            cnt        <= '0;
            cm_cnt     <= '0;
            sub_cnt    <= '0;
            echo       <= 1'b0;
            busy       <= 1'b0;
            no_obj     <= 1'b0;
            trig_short <= 1'b0;
        end else begin
            trig_q     <= trig_s;
            trig_short <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (trig_rise) begin
                        state  <= ST_TRIG_HI;
                        hi_cnt <= HI_W'(1);
                    end
                end
                ST_TRIG_HI: begin
                    if (!trig_s) begin
                        if (hi_cnt >= HI_MIN) begin
                            state <= ST_BURST;
                            busy  <= 1'b1;
                            cnt   <= BURST_LOAD;
                            if (dist_valid(dist_cm, MAX_CM)) begin
                                no_obj <= 1'b0;
                                cm_cnt <= dist_cm;
                            end else begin
                                no_obj <= 1'b1;
                                cm_cnt <= '0;
                            end
                        end else begin
                            trig_short <= 1'b1;
                            state      <= ST_IDLE;
                        end
                    end else if (hi_cnt < HI_MIN) begin
                        hi_cnt <= hi_cnt + 1'b1;
                    end
                end
                ST_BURST: begin
                    if (cnt == '0) begin
                        state   <= ST_ECHO;
                        echo    <= 1'b1;
                        cnt     <= TMO_LOAD;
                        sub_cnt <= SUB_LOAD;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_ECHO: begin
                    // Width is cm_cnt passes of CYC_PER_CM cycles, or TIMEOUT_CYC when no_obj.
                    if (no_obj) begin
                        if (cnt == '0) begin
                            state <= ST_HOLDOFF;
                            echo  <= 1'b0;
                            cnt   <= HOLD_LOAD;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end else if (sub_cnt == '0) begin
                        if (cm_cnt <= DIST_W'(1)) begin
                            state <= ST_HOLDOFF;
                            echo  <= 1'b0;
                            cnt   <= HOLD_LOAD;
                        end else begin
                            cm_cnt  <= cm_cnt - 1'b1;
                            sub_cnt <= SUB_LOAD;
                        end
                    end else begin
                        sub_cnt <= sub_cnt - 1'b1;
                    end
                end
                ST_HOLDOFF: begin
                    if (cnt == '0) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ultrasonic_echo_responder.sv
// Directed bench for ultrasonic_echo_responder (small sim params) plus two default-param instances.
// t counts edges after the edge k that first samples trig low; a value seen #1 after edge k+t is sampled at k+t+1.
module tb_ultrasonic_echo_responder;

`ifdef ECHO_TRIG_SYNC_EN
    localparam int SL = 2;
`else
    localparam int SL = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       trig;
    logic [8:0] dist_cm;
    logic       echo, busy, no_obj, trig_short;

    logic       trig_big;
    logic [8:0] dist8, dist9;
    logic       echo8, busy8, no_obj8, short8;
    logic       echo9, busy9, no_obj9, short9;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ultrasonic_echo_responder #(
        .TRIG_MIN_CYC (5),
        .BURST_CYC    (20),
        .CYC_PER_CM   (10),
        .MAX_CM       (40),
        .TIMEOUT_CYC  (600),
        .HOLDOFF_CYC  (50)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .trig       (trig),
        .dist_cm    (dist_cm),
        .echo       (echo),
        .busy       (busy),
        .no_obj     (no_obj),
        .trig_short (trig_short)
    );

    ultrasonic_echo_responder dut_d8 (
        .clk        (clk),
        .rst_n      (rst_n),
        .trig       (trig_big),
        .dist_cm    (dist8),
        .echo       (echo8),
        .busy       (busy8),
        .no_obj     (no_obj8),
        .trig_short (short8)
    );

    ultrasonic_echo_responder dut_d9 (
        .clk        (clk),
        .rst_n      (rst_n),
        .trig       (trig_big),
        .dist_cm    (dist9),
        .echo       (echo9),
        .busy       (busy9),
        .no_obj     (no_obj9),
        .trig_short (short9)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // mode 1: retrigger during ECHO and HOLDOFF, leave trig high; mode 3: change dist_cm mid-BURST
    task automatic measure(input int hi, input int mode, input int limit,
                           output int t_busy, output int t_rise, output int t_fall,
                           output int t_idle, output int n_short, output int t_short,
                           output int nobj);
        t_busy = -1; t_rise = -1; t_fall = -1; t_idle = -1;
        n_short = 0; t_short = -1; nobj = -1;
        trig = 1'b1;
        repeat (hi) tick();
        trig = 1'b0;
        for (int t = 0; t < limit && t_idle < 0; t++) begin
            tick();
            if (busy && t_busy < 0) t_busy = t;
            if (echo && t_rise < 0) begin
                t_rise = t;
                nobj = int'(no_obj);
            end
            if (!echo && t_rise >= 0 && t_fall < 0) t_fall = t;
            if (!busy && t_busy >= 0 && t_idle < 0) t_idle = t;
            if (trig_short) begin
                n_short++;
                if (t_short < 0) t_short = t;
            end
            if (mode == 1) begin
                if (t == 30) trig = 1'b1;
                else if (t == 36) trig = 1'b0;
                else if (t == 90) trig = 1'b1;
            end
            if (mode == 3 && t == 10) dist_cm = 9'd30;
        end
    endtask

    initial begin
        int tb, tr, tf, ti, ns, ts, nb;
        int r8, f8, r9, f9, nb8, nb9, sh;
        rst_n = 1'b0; trig = 1'b0; dist_cm = 9'd0;
        trig_big = 1'b0; dist8 = 9'd8; dist9 = 9'd9;
        repeat (3) tick();
        chk("rst_echo", int'(echo), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_no_obj", int'(no_obj), 0);
        chk("rst_trig_short", int'(trig_short), 0);
        rst_n = 1'b1;
        tick();

        // 10 cm, 6-cycle trig: 100-cycle echo
        dist_cm = 9'd10;
        measure(6, 0, 400, tb, tr, tf, ti, ns, ts, nb);
        chk("d10_busy_rise", tb, SL);
        chk("d10_echo_rise", tr, SL + 20);
        chk("d10_echo_width", tf - tr, 100);
        chk("d10_busy_fall", ti, SL + 170);
        chk("d10_no_obj", nb, 0);
        chk("d10_no_short", ns, 0);
        repeat (3) tick();

        // 4-cycle trig is rejected
        measure(4, 0, 60, tb, tr, tf, ti, ns, ts, nb);
        chk("short_pulses", ns, 1);
        chk("short_when", ts, SL);
        chk("short_no_busy", tb, -1);
        chk("short_no_echo", tr, -1);

        // exactly TRIG_MIN_CYC high is accepted; 0 cm and 41 cm time out
        dist_cm = 9'd0;
        measure(5, 0, 900, tb, tr, tf, ti, ns, ts, nb);
        chk("d0_echo_width", tf - tr, 600);
        chk("d0_no_obj", nb, 1);
        chk("d0_busy_fall", ti, SL + 670);
        repeat (3) tick();
        dist_cm = 9'd41;
        measure(6, 0, 900, tb, tr, tf, ti, ns, ts, nb);
        chk("d41_echo_width", tf - tr, 600);
        chk("d41_no_obj", nb, 1);
        chk("d41_no_obj_latched", int'(no_obj), 1);
        repeat (3) tick();
        dist_cm = 9'd40;
        measure(6, 0, 900, tb, tr, tf, ti, ns, ts, nb);
        chk("d40_echo_width", tf - tr, 400);
        chk("d40_no_obj", nb, 0);
        repeat (3) tick();

        // retrigger during ECHO and HOLDOFF is ignored; trig left high blocks a new measurement
        dist_cm = 9'd5;
        measure(6, 1, 400, tb, tr, tf, ti, ns, ts, nb);
        chk("retrig_echo_rise", tr, SL + 20);
        chk("retrig_echo_width", tf - tr, 50);
        chk("retrig_busy_fall", ti, SL + 120);
        chk("retrig_no_short", ns, 0);
        repeat (20) tick();
        chk("held_trig_busy", int'(busy), 0);
        chk("held_trig_echo", int'(echo), 0);
        trig = 1'b0;
        repeat (3) tick();

        // reset in the middle of ECHO
        dist_cm = 9'd10;
        trig = 1'b1;
        repeat (6) tick();
        trig = 1'b0;
        repeat (41) tick();
        chk("pre_rst_echo", int'(echo), 1);
        rst_n = 1'b0;
        tick();
        chk("mid_rst_echo", int'(echo), 0);
        chk("mid_rst_busy", int'(busy), 0);
        rst_n = 1'b1;
        repeat (3) tick();
        dist_cm = 9'd7;
        measure(6, 0, 400, tb, tr, tf, ti, ns, ts, nb);
        chk("post_rst_echo_rise", tr, SL + 20);
        chk("post_rst_echo_width", tf - tr, 70);
        repeat (3) tick();

        // dist_cm changed mid-BURST does not alter the latched width
        dist_cm = 9'd3;
        measure(6, 3, 400, tb, tr, tf, ti, ns, ts, nb);
        chk("latch_echo_width", tf - tr, 30);
        chk("latch_busy_fall", ti, SL + 100);
        repeat (3) tick();

        // default parameters, 501-cycle trig: 8 cm and 9 cm
        r8 = -1; f8 = -1; r9 = -1; f9 = -1; nb8 = -1; nb9 = -1; sh = 0;
        trig_big = 1'b1;
        repeat (501) tick();
        trig_big = 1'b0;
        for (int t = 0; t < 40000 && (f8 < 0 || f9 < 0); t++) begin
            tick();
            if (echo8 && r8 < 0) begin r8 = t; nb8 = int'(no_obj8) + 2 * int'(busy8); end
            if (!echo8 && r8 >= 0 && f8 < 0) f8 = t;
            if (echo9 && r9 < 0) begin r9 = t; nb9 = int'(no_obj9) + 2 * int'(busy9); end
            if (!echo9 && r9 >= 0 && f9 < 0) f9 = t;
            sh += int'(short8) + int'(short9);
        end
        chk("def8_echo_rise", r8, SL + 10000);
        chk("def8_echo_width", f8 - r8, 23200);
        chk("def8_busy_no_obj", nb8, 2);
        chk("def9_echo_rise", r9, SL + 10000);
        chk("def9_echo_width", f9 - r9, 26100);
        chk("def9_busy_no_obj", nb9, 2);
        chk("def_no_short", sh, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
